// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO owner and fixed-latency mult/div sequencer for the E stage.
// Define MDU_DIV0_KEEP_EN to leave HI/LO untouched on divide by zero.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);
  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [31:0] hi_p, lo_p;
  logic        is_mul, is_div;
  logic [63:0] sprod, uprod, div0, res;
  logic [31:0] ma, mb, uq, ur, sq, sr;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_div = op == OP_DIV || op == OP_DIVU;
  assign start  = (is_mul || is_div) && !req && state == IDLE;
  assign md_out = op == OP_MFHI ? HI : op == OP_MFLO ? LO : '0;
  assign sprod  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign uprod  = {32'b0, A} * {32'b0, B};
  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign ma = A[31] ? -A : A;
  assign mb = B[31] ? -B : B;
  assign uq = ma / mb;
  assign ur = ma % mb;
  assign sq = (A[31] ^ B[31]) ? -uq : uq;
  assign sr = A[31] ? -ur : ur;
`ifdef MDU_DIV0_KEEP_EN
  assign div0 = {HI, LO};
`else
  assign div0 = {A, 32'hFFFF_FFFF};
`endif
  assign res = op == OP_MULT  ? sprod :
               op == OP_MULTU ? uprod :
               B == '0        ? div0  :
               op == OP_DIV   ? {sr, sq} : {A % B, A / B};
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = BUSY;
    else if (state == BUSY && cnt == 5'd1) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      hi_p  <= '0;
      lo_p  <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        {hi_p, lo_p} <= res;
        cnt          <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
        busy         <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          HI   <= hi_p;
          LO   <= lo_p;
          busy <= 1'b0;
        end
      end else if (!req) begin
        if (op == OP_MTHI) HI <= A;
        if (op == OP_MTLO) LO <= A;
      end
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && state == BUSY && op != OP_NONE)
      $display("mdu_ctrl: op %b ignored while busy (hazard unit let it through)", op);
`endif
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven, hand-sequenced and randomized checks of mdu_ctrl.
// Honors MDU_DIV0_KEEP_EN the same way the design does.
module tb_mdu_ctrl;
  logic        clk = 0, reset = 1, req = 0, start, busy;
  logic [3:0]  op = 0;
  logic [31:0] A = 0, B = 0, HI, LO, md_out;
  int          checks = 0, errors = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  mdu_ctrl dut (.clk(clk), .reset(reset), .op(op), .A(A), .B(B), .req(req),
                .start(start), .busy(busy), .HI(HI), .LO(LO), .md_out(md_out));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
  } vec_t;
  vec_t tv[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] a, b, hi, lo);
    longint x, y, q, r;
    longint unsigned p;
    if (o == 4'd1) begin
      q = longint'($signed(a)) * longint'($signed(b));
      return q;
    end
    if (o == 4'd3) begin
      p = longint'(a) * longint'(b);
      return p;
    end
`ifdef MDU_DIV0_KEEP_EN
    if (b == 0) return {hi, lo};
`else
    if (b == 0) return {a, 32'hFFFF_FFFF};
`endif
    if (o == 4'd2) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] a, b, eh, el, input int n);
    int nb = 0;
    @(negedge clk);
    op = o; A = a; B = b; req = 0;
    #1 check("start_at_issue", start, 1);
    @(negedge clk);
    op = 0; A = $urandom; B = $urandom;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, n);
    check("hi_commit", HI, eh);
    check("lo_commit", LO, el);
    m_hi = eh; m_lo = el;
    op = 4'b0110;
    #1 check("mflo", md_out, el);
    op = 4'b0101;
    #1 check("mfhi", md_out, eh);
    op = 0;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] a, input logic r);
    @(negedge clk);
    op = o; A = a; req = r;
    #1 check("mt_no_start", start, 0);
    if (!r && o == 4'b0111) m_hi = a;
    if (!r && o == 4'b1000) m_lo = a;
    @(negedge clk);
    op = 0; req = 0;
    check("mt_busy", busy, 0);
    check("mt_hi", HI, m_hi);
    check("mt_lo", LO, m_lo);
  endtask

  initial begin
    logic [63:0] e;
    logic [3:0]  ops[6] = '{4'd1, 4'd3, 4'd2, 4'd4, 4'd7, 4'd8};
    logic [3:0]  o;
    logic [31:0] a, b;
    int          nb;
    tv[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tv[1] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    tv[2] = '{4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tv[3] = '{4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
    tv[4] = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10};
`ifdef MDU_DIV0_KEEP_EN
    tv[5] = '{4'd2, 32'd5, 32'd0, 32'd0, 32'h8000_0000, 10};
`else
    tv[5] = '{4'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10};
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_start", start, 0);
    for (int i = 0; i < 6; i++) issue(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].n);
    // mthi then mtlo on back-to-back cycles, then a flushed mthi
    @(negedge clk);
    op = 4'b0111; A = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_busy", busy, 0);
    op = 4'b1000; A = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    check("mtlo_hi", HI, 32'h1234_5678);
    op = 4'b0111; A = 32'hDEAD_BEEF; req = 1;
    @(negedge clk);
    check("mthi_req_hi", HI, 32'h1234_5678);
    op = 0; req = 0;
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    // flushed mult never starts
    @(negedge clk);
    op = 4'b0001; A = 3; B = 4; req = 1;
    #1 check("req_no_start", start, 0);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = 0; req = 0;
      nb += int'(busy);
    end
    check("req_busy_never", nb, 0);
    check("req_hi_kept", HI, m_hi);
    check("req_lo_kept", LO, m_lo);
    // undefined op code behaves as none
    @(negedge clk);
    op = 4'hF; A = 32'h5555_5555;
    #1 check("bad_op_start", start, 0);
    @(negedge clk);
    op = 0;
    check("bad_op_hi", HI, m_hi);
    check("bad_op_lo", LO, m_lo);
    // ops arriving while busy are ignored; req does not cancel
    @(negedge clk);
    op = 4'b0001; A = 7; B = 6;
    @(negedge clk);
    op = 4'b1000; A = 32'h1111; req = 1;
    @(negedge clk);
    op = 4'b0111; A = 32'h2222; req = 0;
    @(negedge clk);
    op = 4'b0001; A = 9; B = 9;
    @(negedge clk);
    op = 0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check("busy_ignore_done", nb < 40, 1);
    check("busy_ignore_lo", LO, 32'd42);
    check("busy_ignore_hi", HI, 32'd0);
    // reset during busy cycle 3 aborts without commit
    @(negedge clk);
    op = 4'b0010; A = 100; B = 7;
    @(negedge clk);
    op = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort_busy", busy, 0);
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    nb = 0;
    repeat (15) begin
      @(negedge clk);
      nb += int'(busy);
    end
    check("abort_no_busy", nb, 0);
    check("abort_no_commit_hi", HI, 0);
    check("abort_no_commit_lo", LO, 0);
    m_hi = 0; m_lo = 0;
    // randomized ops against the reference model
    for (int i = 0; i < 25; i++) begin
      o = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (o == 4'd7 || o == 4'd8) mt(o, a, 1'($urandom_range(0, 1)));
      else begin
        e = ref_res(o, a, b, m_hi, m_lo);
        issue(o, a, b, e[63:32], e[31:0], (o == 4'd1 || o == 4'd3) ? 5 : 10);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and owner of the HI/LO multiply/divide resource in the E stage of the pipelined CPU.
- Accepts the 4-bit mult/div opcode produced by the decoder and starts a fixed-latency multiply or divide.
- Holds HI/LO, serves mfhi/mflo/mthi/mtlo, and drives start/busy to the hazard unit, which stalls D-stage mult/div-class instructions.
- Respects the exception/interrupt flush so that a victim instruction never modifies HI/LO.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, number of busy cycles for div/divu (legal range 1..31).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- op  in  4  E-stage op: 0000 none, 0001 mult, 0011 multu, 0010 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo; other codes are treated as none.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- req  in  1  exception/interrupt flush of the E-stage instruction; suppresses any start or mt write this cycle.
- start  out  1  combinational; 1 when op is mult/multu/div/divu, req=0 and state is IDLE.
- busy  out  1  registered; 1 while an operation is in flight.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- md_out  out  32  combinational; HI for mfhi, LO for mflo, otherwise 0.

Behaviour:
- Reset: state=IDLE, cnt=0, busy=0, HI=0, LO=0, and pending registers=0. Reset in the middle of an operation aborts it; no HI/LO commit occurs.
- FSM has two states, IDLE and BUSY.
- IDLE -> BUSY when start=1 at an edge:
  - compute the result into pending hi_p/lo_p;
  - cnt <= MULT_CYCLES or DIV_CYCLES;
  - busy <= 1.
- BUSY: cnt decrements each cycle.
  - At the edge where cnt==1: HI<=hi_p, LO<=lo_p, busy<=0, state<=IDLE.
- Timing: issue at edge T gives busy=1 for exactly N cycles; the new HI/LO are visible from cycle T+N+1. The same-cycle start followed by busy lets the hazard unit stall on (start|busy).
- mult: signed 64-bit product of A and B; HI = [63:32], LO = [31:0].
- multu: unsigned 64-bit product of A and B; HI = [63:32], LO = [31:0].
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: see Optional Feature; the result is never X.
- mthi/mtlo in IDLE with req=0: HI (resp. LO) <= A at the next edge, zero latency, busy stays 0.
- mfhi/mflo: md_out reflects the current HI/LO combinationally. Read-during-write shows the old value; the hazard unit guarantees no mf is issued while start|busy.
- Any op other than none arriving while BUSY is ignored: no restart, no mt write. This is a hazard-unit bug; flag it with a simulation-only $display.
- req=1: start=0 and mt writes are suppressed that cycle.
- req does not cancel an operation already in BUSY. It completes and commits, per our precise-exception model; the instruction was already past E when the exception was taken.
- A and B are only sampled at the issue edge; later changes have no effect.

Optional Feature:
- Macro MDU_DIV0_KEEP_EN.
- Defined: div/divu with B==0 still runs DIV_CYCLES busy, but HI and LO are left unchanged at completion.
- Undefined: div/divu with B==0 commits LO=0xFFFFFFFF and HI=A (both signed and unsigned).

Test Plan:
- reset, then mult A=0xFFFFFFFE(-2) B=3 -> start=1 at issue; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; md_out for mflo = 0xFFFFFFFA.
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9(-7) B=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI and LO update the next edge each; busy stays 0. Repeat mthi with req=1 -> HI unchanged.
- mult issued with req=1 -> start=0, busy never rises, HI/LO unchanged. mult issued, then req=1 and op=mtlo during BUSY -> op ignored, product still commits.
- div A=5 B=0 -> macro off: LO=0xFFFFFFFF, HI=5; macro on: HI/LO retain prior values; busy lasts 10 cycles in both. Reset asserted at busy cycle 3 -> busy=0, HI=LO=0 next cycle, no later commit.
